counter_ctrl: RTL

- Sequencing controller for the team's 4-bit loadable up/down counter; drives that counter's `mode`, `load` and `data` inputs and consumes its `RCO` output.
- Accepts a command (start value, direction, number of terminal-count events) over a valid/ready handshake and loads the counter.
- Counts RCO events and reports completion, plus a watchdog error if RCO stops arriving.
- Sits between the host/sequencer logic and one counter instance.

---
 rtl/counter_ctrl_pkg.sv | 43 ++++
 rtl/counter_ctrl_rco_event_counter.sv | 85 ++++++++
 rtl/counter_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Definitions shared by the counter sequencing controller and its RCO event
// counter:
//   - default data and repeat widths
//   - FSM state type and state constants (IDLE/LOAD/RUN/DONE)
//   - terminal counts for the up and down directions
//   - watchdog limit
//   - helper functions, so that modules built with non-default widths get the
//     matching terminal and watchdog values
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_REP_W = 8;

  // The state encoding is kept as plain constants so that existing consumers
  // comparing against raw 2-bit values continue to work.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Terminal values of the default-width counter: RCO fires on them.
  localparam int unsigned TERM_UP  = (1 << DEF_WIDTH) - 1;
  localparam int unsigned TERM_DN  = 0;

  // A healthy counter produces an RCO within 2^WIDTH cycles. One extra cycle
  // of slack keeps the watchdog from firing on the longest legal gap.
  localparam int unsigned WDOG_MAX = (1 << DEF_WIDTH) + 1;

  function automatic int unsigned term_value(input int unsigned width,
                                             input logic        up);
    return up ? ((1 << width) - 1) : 0;
  endfunction

  function automatic int unsigned wdog_limit(input int unsigned width);
    return (1 << width) + 1;
  endfunction

endpackage : counter_ctrl_pkg

// File: rtl/counter_ctrl_rco_event_counter.sv
// -----------------------------------------------------------------------------
// rco_event_counter
// Tracks the progress of one counter run, as seen through the RCO line.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   command accepted: latch reps and clear evt_cnt
//   reps       in   required events minus one
//   arm        in   LOAD cycle: clear the watchdog
//   run_en     in   RUN cycle, not aborted: sample rco_in
//   rco_in     in   RCO from the counter
//   evt_cnt    out  saturating count of RCO events in this run
//   last_event out  the RCO sampled this cycle completes the run
//   timeout    out  the watchdog expires this cycle
//
// last_event and timeout are combinational look-aheads. The FSM registers
// them into done and err at the same edge that the counters here update.
// -----------------------------------------------------------------------------
module rco_event_counter
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REP_W-1:0] reps,
  input  logic             arm,
  input  logic             run_en,
  input  logic             rco_in,
  output logic [REP_W-1:0] evt_cnt,
  output logic             last_event,
  output logic             timeout
);

  // The watchdog has to be able to hold 2^WIDTH+1.
  localparam int unsigned      WDOG_W    = WIDTH + 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(wdog_limit(WIDTH) - 1);
  localparam logic [REP_W-1:0]  EVT_SAT   = '1;

  logic [REP_W-1:0]  rep_left;
  logic [WDOG_W-1:0] wdog;

  // rep_left reaching zero means the event seen now is the last one required.
  assign last_event = run_en &  rco_in & (rep_left == '0);
  // The quiet cycle that would take wdog to the limit raises err directly,
  // so err appears on the same edge that the limit is reached.
  assign timeout    = run_en & ~rco_in & (wdog == WDOG_LAST);

  // NOTE: state is updated with non-blocking assignments only. Every register
  //       then sees pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_cnt  <= '0;
      rep_left <= '0;
      wdog     <= '0;
    end else begin
      if (start) begin
        rep_left <= reps;
        evt_cnt  <= '0;
      end

      if (arm) begin
        wdog <= '0;
      end

      if (run_en) begin
        if (rco_in) begin
          wdog <= '0;
          if (evt_cnt != EVT_SAT) begin
            evt_cnt <= evt_cnt + 1'b1;
          end
          if (rep_left != '0) begin
            rep_left <= rep_left - 1'b1;
          end
        end else begin
          wdog <= wdog + 1'b1;
        end
      end
    end
  end

endmodule : rco_event_counter

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
// Sequencing controller for one 4-bit loadable up/down counter. It does three
// things:
//   - accepts a command (start value, direction, repeat count) over a
//     valid/ready handshake;
//   - loads the counter, then counts the RCO events that follow;
//   - reports completion with done, or a stalled counter with err.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   cmd_valid  in   command offered
//   cmd_ready  out  controller can accept a command (IDLE only)
//   cmd_data   in   counter start value
//   cmd_mode   in   1 = count up (terminal 2^WIDTH-1), 0 = down (terminal 0)
//   cmd_reps   in   required RCO events minus one
//   abort      in   synchronous cancel, highest priority
//   rco_in     in   RCO from the counter
//   load       out  counter load strobe
//   data       out  counter load value
//   mode       out  counter direction
//   busy       out  run in progress (LOAD or RUN)
//   done       out  one-cycle completion pulse
//   err        out  one-cycle watchdog-timeout pulse
//   evt_cnt    out  RCO events seen in the current or last run (saturating)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_mode,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             abort,
  input  logic             rco_in,
  output logic             load,
  output logic [WIDTH-1:0] data,
  output logic             mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REP_W-1:0] evt_cnt
);

  state_t state;

  logic accept;
  logic in_load;
  logic run_en;
  logic last_event;
  logic timeout;

  // cmd_ready is high only in IDLE, so a handshake implies IDLE.
  // A coincident abort cancels the handshake.
  assign accept  = cmd_valid & cmd_ready & ~abort;
  // During LOAD, rco_in still reflects the count from before the load.
  // It is therefore not sampled until RUN.
  assign in_load = (state == ST_LOAD);
  assign run_en  = (state == ST_RUN) & ~abort;

  rco_event_counter #(
    .WIDTH (WIDTH),
    .REP_W (REP_W)
  ) u_evt (
    .clk        (clk),
    .rst        (rst),
    .start      (accept),
    .reps       (cmd_reps),
    .arm        (in_load),
    .run_en     (run_en),
    .rco_in     (rco_in),
    .evt_cnt    (evt_cnt),
    .last_event (last_event),
    .timeout    (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      load      <= 1'b0;
      data      <= '0;
      mode      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: the pulse outputs get their idle value first. Each branch below
      //       then only names the pulse it raises, and no pulse can stick
      //       high on a path that forgets to clear it.
      load <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;

      if (abort) begin
        state     <= ST_IDLE;
        cmd_ready <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              data      <= cmd_data;
              mode      <= cmd_mode;
              load      <= 1'b1;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              state     <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            state <= ST_RUN;
          end

          ST_RUN: begin
            if (last_event) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else if (timeout) begin
              err       <= 1'b1;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= ST_IDLE;
            end
          end

          ST_DONE: begin
            // The handshake reopens one cycle after done. A command offered
            // during DONE is therefore accepted in the following IDLE cycle.
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end

          default: begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule : counter_ctrl
